multi_player_engine: RTL

MULTI_PLAYER_ENGINE -- requirements
Module: multi_player_engine

---
 rtl/multi_player_engine.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_player_engine.sv
// Tick-driven movement engine for up to four players on a bounded grid.
// Each tick scans players in index order: obstacle lookup, collision check, then erase/draw over a ready/valid pixel port.
module multi_player_engine #(
  parameter int N_PLAYERS   = 2,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int TICK_CYCLES = 1000000,
  parameter int WRAP        = 0,
  parameter int START_X     = 20,
  parameter int START_Y     = 60,
  parameter int SPACING     = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*N_PLAYERS-1:0]   dir_in,
  input  logic [N_PLAYERS-1:0]     dir_valid,
  input  logic                     trail,
  input  logic [2:0]               obs_mem,
  output logic [7:0]               obs_x,
  output logic [6:0]               obs_y,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [2:0]               color_draw,
  output logic                     plot,
  input  logic                     plot_ready,
  output logic [8*N_PLAYERS-1:0]   pos_x,
  output logic [7*N_PLAYERS-1:0]   pos_y,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WAIT   = 3'd2,
    S_DECIDE = 3'd3,
    S_ERASE  = 3'd4,
    S_DRAW   = 3'd5,
    S_NEXT   = 3'd6
  } state_e;

  localparam logic [7:0]  XM        = 8'(X_MAX);
  localparam logic [6:0]  YM        = 7'(Y_MAX);
  localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);
  localparam logic [1:0]  LAST_IDX  = 2'(N_PLAYERS - 1);
  localparam bit          WRAP_EN   = (WRAP != 0);

  state_e      state_r;
  logic [31:0] tick_cnt_r;
  logic        tick_s;
  logic        pending_r;
  logic [1:0]  idx_r;
  logic [3:0]  moving_r;
  logic        go_r;
  logic        oob_r;
  logic [1:0]  dir_r   [4];
  logic [7:0]  pos_x_r [4];
  logic [6:0]  pos_y_r [4];
  logic [7:0]  cur_x_s;
  logic [6:0]  cur_y_s;
  logic [7:0]  cand_x_s;
  logic [6:0]  cand_y_s;
  logic        oob_s;
  logic        hit_s;
  logic        blocked_s;
  logic [2:0]  color_s;

  assign tick_s    = (tick_cnt_r == TICK_LAST);
  assign color_s   = {1'b0, idx_r} + 3'd1;
  assign blocked_s = (obs_mem != 3'd0) || hit_s || (oob_r && !WRAP_EN);
  assign state     = state_r;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pos
    assign pos_x[8*g +: 8] = pos_x_r[g];
    assign pos_y[7*g +: 7] = pos_y_r[g];
  end

  // Free-running movement tick divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= 32'd0;
    end else if (tick_s) begin
      tick_cnt_r <= 32'd0;
    end else begin
      tick_cnt_r <= tick_cnt_r + 32'd1;
    end
  end

  // Per-player heading and moving flag, latched on each strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      moving_r <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        dir_r[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (dir_valid[i]) begin
          dir_r[i]    <= dir_in[2*i +: 2];
          moving_r[i] <= 1'b1;
        end else begin
          dir_r[i]    <= dir_r[i];
          moving_r[i] <= moving_r[i];
        end
      end
    end
  end

  // Candidate cell one step along the current player's heading, with edge detection.
  always_comb begin
    cur_x_s  = pos_x_r[idx_r];
    cur_y_s  = pos_y_r[idx_r];
    cand_x_s = cur_x_s;
    cand_y_s = cur_y_s;
    oob_s    = 1'b0;
    case (dir_r[idx_r])
      2'b00: begin
        if (cur_y_s == 7'd0) begin
          cand_y_s = YM;
          oob_s    = 1'b1;
        end else begin
          cand_y_s = cur_y_s - 7'd1;
        end
      end
      2'b01: begin
        if (cur_x_s >= XM) begin
          cand_x_s = 8'd0;
          oob_s    = 1'b1;
        end else begin
          cand_x_s = cur_x_s + 8'd1;
        end
      end
      2'b10: begin
        if (cur_y_s >= YM) begin
          cand_y_s = 7'd0;
          oob_s    = 1'b1;
        end else begin
          cand_y_s = cur_y_s + 7'd1;
        end
      end
      2'b11: begin
        if (cur_x_s == 8'd0) begin
          cand_x_s = XM;
          oob_s    = 1'b1;
        end else begin
          cand_x_s = cur_x_s - 8'd1;
        end
      end
      default: begin
        oob_s = 1'b1;
      end
    endcase
  end

  // The registered candidate collides with any other player's current cell.
  always_comb begin
    hit_s = 1'b0;
    for (int j = 0; j < N_PLAYERS; j++) begin
      if ((2'(j) != idx_r) && (pos_x_r[j] == obs_x) && (pos_y_r[j] == obs_y)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Scan sequencer: owns positions, lookup address and the pixel write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      pending_r  <= 1'b0;
      idx_r      <= 2'd0;
      go_r       <= 1'b0;
      oob_r      <= 1'b0;
      obs_x      <= 8'd0;
      obs_y      <= 7'd0;
      x          <= 8'd0;
      y          <= 7'd0;
      color_draw <= 3'd0;
      plot       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pos_x_r[i] <= 8'(START_X + i * SPACING);
        pos_y_r[i] <= 7'(START_Y);
      end
    end else begin
      if (tick_s && (state_r != S_IDLE)) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      case (state_r)
        S_IDLE: begin
          if (tick_s || pending_r) begin
            state_r   <= S_LOOKUP;
            idx_r     <= 2'd0;
            pending_r <= 1'b0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOOKUP: begin
          obs_x   <= cand_x_s;
          obs_y   <= cand_y_s;
          oob_r   <= oob_s;
          go_r    <= moving_r[idx_r];
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          state_r <= S_DECIDE;
        end
        S_DECIDE: begin
          if (blocked_s || !go_r) begin
            state_r <= S_NEXT;
          end else begin
            state_r    <= S_ERASE;
            plot       <= 1'b1;
            x          <= pos_x_r[idx_r];
            y          <= pos_y_r[idx_r];
            color_draw <= trail ? color_s : 3'd0;
          end
        end
        S_ERASE: begin
          if (plot_ready) begin
            pos_x_r[idx_r] <= obs_x;
            pos_y_r[idx_r] <= obs_y;
            x              <= obs_x;
            y              <= obs_y;
            color_draw     <= color_s;
            state_r        <= S_DRAW;
          end else begin
            state_r <= S_ERASE;
          end
        end
        S_DRAW: begin
          if (plot_ready) begin
            plot    <= 1'b0;
            state_r <= S_NEXT;
          end else begin
            state_r <= S_DRAW;
          end
        end
        S_NEXT: begin
          if (idx_r == LAST_IDX) begin
            idx_r   <= 2'd0;
            state_r <= S_IDLE;
          end else begin
            idx_r   <= idx_r + 2'd1;
            state_r <= S_LOOKUP;
          end
        end
        default: begin
          plot    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
